// File: rtl/mod_q_pkg.sv
// Shared constants and types for the mod-Q (Q = 2^23 - 2^13 + 1) arithmetic blocks.
// Used by the Fermat inverter and its combinational multiplier.
package mod_q_pkg;

  localparam logic [22:0] Q_MOD          = 23'd8380417;
  localparam logic [22:0] INV_EXP        = 23'h7FDFFF;
  localparam int          EXP_MSB        = 22;
  localparam int          COMPUTE_CYCLES = 45;

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/mod_inv_q_if.sv
// Operand/result handshake bundle for the mod-Q inverter.
// The slave side is the inverter itself; the master side is the client.
interface mod_inv_q_if;

  logic        in_valid;
  logic        in_ready;
  logic [22:0] A;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] Z;
  logic        busy;

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, Z, busy
  );

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, Z, busy
  );

endinterface

// File: rtl/mod_mul_q.sv
// Combinational 23x23 multiply fully reduced mod Q.
// Reduction folds the high part using 2^23 == 2^13 - 1 (mod Q), then one conditional subtract.
module mod_mul_q
  import mod_q_pkg::*;
(
  input  logic [22:0] a,
  input  logic [22:0] b,
  output logic [22:0] p
);

  logic [45:0] prod;
  logic [36:0] r1;
  logic [27:0] r2;
  logic [23:0] r3;
  logic [22:0] r4;

  // Each fold replaces hi*2^23 by hi*2^13 - hi; four folds bring the value below 2^23 < 2Q.
  always_comb begin
    prod = 46'(a) * 46'(b);
    r1   = {14'b0, prod[22:0]} + {1'b0, prod[45:23], 13'b0} - {14'b0, prod[45:23]};
    r2   = {5'b0, r1[22:0]} + {1'b0, r1[36:23], 13'b0} - {14'b0, r1[36:23]};
    r3   = {1'b0, r2[22:0]} + {6'b0, r2[27:23], 13'b0} - {19'b0, r2[27:23]};
    r4   = r3[22:0] + (r3[23] ? 23'd8191 : 23'd0);
    p    = (r4 >= Q_MOD) ? (r4 - Q_MOD) : r4;
  end

endmodule

// File: rtl/mod_inv_q.sv
// Sequential mod-Q inverter: Z = A^(Q-2) mod Q via left-to-right square-and-multiply,
// one modular multiplication per clock on a single shared multiplier.
module mod_inv_q
  import mod_q_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mod_inv_q_if.slave io
);

  state_t      state, state_nxt;
  logic [22:0] acc, acc_nxt;
  logic [22:0] a_r, a_r_nxt;
  logic [4:0]  idx, idx_nxt;
  logic [22:0] a_red;
  logic [22:0] mul_b;
  logic [22:0] mul_p;
  logic        exp_bit;

  assign a_red   = (io.A >= Q_MOD) ? (io.A - Q_MOD) : io.A;
  assign exp_bit = INV_EXP[idx];
  assign mul_b   = (state == MUL) ? a_r : acc;

  mod_mul_q u_mul (
    .a (acc),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      a_r   <= '0;
      idx   <= 5'(EXP_MSB);
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      a_r   <= a_r_nxt;
      idx   <= idx_nxt;
    end
  end

  // A set exponent bit inserts a MUL after the SQR at the same idx; MUL then moves idx on.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    a_r_nxt   = a_r;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (io.in_valid) begin
          a_r_nxt   = a_red;
          acc_nxt   = 23'd1;
          idx_nxt   = 5'(EXP_MSB);
          state_nxt = SQR;
        end
      end
      SQR: begin
        acc_nxt = mul_p;
        if (exp_bit) begin
          state_nxt = MUL;
        end else if (idx == 5'd0) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx - 5'd1;
        end
      end
      MUL: begin
        acc_nxt = mul_p;
        if (idx == 5'd0) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx - 5'd1;
          state_nxt = SQR;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state == SQR) || (state == MUL);
  assign io.Z         = (state == DONE) ? {1'b0, acc} : 24'd0;

endmodule

// File: doc/mod_inv_q.md
Name: mod_inv_q

Overview:
- Sequential modular inverter over the Dilithium prime Q = 8380417 (2^23 - 2^13 + 1).
- Computes Z = A^(Q-2) mod Q, which equals A^-1 mod Q for A != 0, using Fermat left-to-right square-and-multiply.
- Performs one modular multiplication per clock on a single shared combinational mod-Q multiplier.
- Undoes the multiply direction: it feeds NTT scaling constants and divides out results of the existing modular multiplier.

Parameters:
- None. Q and the exponent are fixed constants in the shared package.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand A valid
- in_ready  output  1  block can accept an operand
- A  input  23  operand, any value 0..2^23-1
- out_valid  output  1  result Z valid
- out_ready  input  1  consumer accepts Z
- Z  output  24  result in [0, Q-1]; bit 23 is always 0
- busy  output  1  computation in progress

Behaviour:
- Reset: sampled on the clk edge with rst_n = 0. State goes to IDLE. in_ready = 1, out_valid = 0, busy = 0, Z = 0, acc = 0, idx = 22.
- Reset mid-operation discards the operation; no output is produced.
- States: IDLE, SQR, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On an in_valid & in_ready edge, latch a_r = (A >= Q) ? A - Q : A (single conditional subtract), set acc = 1, set idx = 22, go to SQR.
- SQR:
  - acc <= acc*acc mod Q.
  - If EXP[idx] = 1, go to MUL.
  - Else if idx = 0, go to DONE.
  - Else idx <= idx - 1 and stay in SQR.
- MUL:
  - acc <= acc*a_r mod Q.
  - If idx = 0, go to DONE; else idx <= idx - 1 and go to SQR.
- DONE:
  - out_valid = 1 and Z = {1'b0, acc}.
  - Z and out_valid stay stable until out_valid & out_ready.
  - On that edge, go to IDLE. The same edge does not accept a new operand, because in_ready is 0 in DONE.
- EXP = Q - 2 = 0x7FDFFF. Bits 22..0 are all 1 except bit 13.
- Result: 23 SQR cycles + 22 MUL cycles = 45 compute cycles, fixed and data-independent.
- Latency: out_valid is first high in the 45th cycle after the accepting edge. Exactly 45 edges after accept, the state is DONE.
- busy = 1 in SQR and MUL only. in_ready = 1 only in IDLE.
- Arithmetic:
  - Multiplier operands are 23 bits and the product is 46 bits.
  - The reduced result is fully reduced to [0, Q-1] and stored as 23 bits.
  - No lazy reduction is allowed: acc < Q at every cycle.
- A = 0 or A = Q: reduces to 0, so Z = 0 with no special-case path.
- A in [Q+1, 2^23-1]: reduced once, then inverted.
- in_valid while not IDLE is ignored (no latch, no error).
- A may change freely after the accept edge.

Decomposition:
- Shared package mod_q_pkg holds:
  - Q_MOD = 23'd8380417
  - INV_EXP = 23'h7FDFFF
  - state enum {IDLE, SQR, MUL, DONE}
  - EXP_MSB = 22
  - COMPUTE_CYCLES = 45
- One sub-module, mod_mul_q: purely combinational 23x23 multiply reduced mod Q, with output fully reduced.
  - Its algorithm is the shift-and-add reduction 2^23 ≡ 2^13 - 1 plus a final conditional subtract, matching the team's existing modular multiplier.
  - It is instantiated once. Its operand mux (acc or a_r) is driven by the FSM.

Test Plan:
- A=1 -> Z=1. out_valid first seen 45 cycles after accept; busy high exactly 45 cycles.
- A=2 -> Z=4190209. A=3 -> Z=5586945. Check (A*Z) mod Q = 1 for both.
- A=8380416 (Q-1) -> Z=8380416. A=0 -> Z=0. A=8380417 (Q) -> Z=0. A=8380418 -> Z=1 (reduced to 1).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> Z and out_valid stable. in_valid pulses during that time are not accepted. Raising out_ready -> IDLE next edge, and in_ready=1.
- Reset mid-op: rst_n=0 for one edge at compute cycle 20 -> IDLE, out_valid never asserted. A following A=2 -> Z=4190209 with full 45-cycle latency.
- Random regression: 10k random A, checked against a reference model of pow(A mod Q, Q-2, Q). Back-to-back operations with out_ready tied to 1.
